// File: rtl/rob_dispatch.sv
// Dispatch stage: queues renamed instructions and issues up to 4 per cycle into the ROB with credit tracking.
// Optional statistics counters are enabled with the DISPATCH_STATS_EN macro.
module rob_dispatch #(
    parameter int QDEPTH   = 8,
    parameter int ROB_SIZE = 128,
    parameter int IDX_W    = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        in_valid,
    input  logic [4:0]        in_archReg0,
    input  logic [4:0]        in_archReg1,
    input  logic [4:0]        in_archReg2,
    input  logic [4:0]        in_archReg3,
    input  logic [7:0]        in_physReg0,
    input  logic [7:0]        in_physReg1,
    input  logic [7:0]        in_physReg2,
    input  logic [7:0]        in_physReg3,
    input  logic [10:0]       in_opcode0,
    input  logic [10:0]       in_opcode1,
    input  logic [10:0]       in_opcode2,
    input  logic [10:0]       in_opcode3,
    output logic              in_ready,
    input  logic [2:0]        numCommited,
    input  logic              full,
    input  logic              flushInst,
    output logic [3:0]        inserted,
    output logic [4:0]        archReg0,
    output logic [4:0]        archReg1,
    output logic [4:0]        archReg2,
    output logic [4:0]        archReg3,
    output logic [7:0]        physReg0,
    output logic [7:0]        physReg1,
    output logic [7:0]        physReg2,
    output logic [7:0]        physReg3,
    output logic [10:0]       opcode0,
    output logic [10:0]       opcode1,
    output logic [10:0]       opcode2,
    output logic [10:0]       opcode3,
    output logic [IDX_W-1:0]  robIndex0,
    output logic [IDX_W-1:0]  robIndex1,
    output logic [IDX_W-1:0]  robIndex2,
    output logic [IDX_W-1:0]  robIndex3,
    output logic [IDX_W:0]    robOccupancy
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]       stallCycles,
    output logic [31:0]       dispatchedTotal
`endif
);

    localparam int PW = $clog2(QDEPTH);

    typedef struct packed {
        logic [4:0]  arch;
        logic [7:0]  phys;
        logic [10:0] op;
    } entry_t;

    entry_t          mem [QDEPTH];
    entry_t          lane_in [4];
    entry_t          out_q [4];
    logic [IDX_W-1:0] idx_q [4];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [PW:0]     count;
    logic [IDX_W-1:0] tail;
    logic [IDX_W:0]  occ;
    logic [IDX_W:0]  credit;
    logic [IDX_W+1:0] occ_sum;
    logic [IDX_W:0]  occ_next;
    logic [3:0]      accept;
    logic [2:0]      off [4];
    logic [2:0]      n_acc;
    logic [2:0]      n;
    logic [3:0]      therm;

    assign lane_in[0] = {in_archReg0, in_physReg0, in_opcode0};
    assign lane_in[1] = {in_archReg1, in_physReg1, in_opcode1};
    assign lane_in[2] = {in_archReg2, in_physReg2, in_opcode2};
    assign lane_in[3] = {in_archReg3, in_physReg3, in_opcode3};

    assign in_ready = (count <= (PW+1)'(QDEPTH - 4));
    assign accept   = in_valid & {4{in_ready & ~flushInst}};

    // Compaction: each accepted lane lands at the tail plus the number of accepted lanes below it.
    always_comb begin
        off[0] = 3'd0;
        for (int i = 1; i < 4; i++)
            off[i] = off[i-1] + 3'(accept[i-1]);
        n_acc = off[3] + 3'(accept[3]);
    end

    assign credit = (IDX_W+1)'(ROB_SIZE) - occ;

    always_comb begin
        n = 3'd0;
        if (!flushInst && !full) begin
            n = 3'd4;
            if (count < (PW+1)'(4))
                n = 3'(count);
            if (credit < (IDX_W+1)'(n))
                n = 3'(credit);
        end
    end

    always_comb begin
        case (n)
            3'd1:    therm = 4'b0001;
            3'd2:    therm = 4'b0011;
            3'd3:    therm = 4'b0111;
            3'd4:    therm = 4'b1111;
            default: therm = 4'b0000;
        endcase
    end

    // Commit credit this cycle is applied after dispatch; over-commit clamps to empty.
    assign occ_sum  = {1'b0, occ} + (IDX_W+2)'(n);
    assign occ_next = ((IDX_W+2)'(numCommited) > occ_sum) ? '0
                    : (IDX_W+1)'(occ_sum - (IDX_W+2)'(numCommited));

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            tail     <= '0;
            occ      <= '0;
            inserted <= '0;
            for (int i = 0; i < 4; i++) begin
                out_q[i] <= '0;
                idx_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++)
                if (accept[i])
                    mem[wr_ptr + PW'(off[i])] <= lane_in[i];
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < n) begin
                    out_q[i] <= mem[rd_ptr + PW'(i)];
                    idx_q[i] <= tail + IDX_W'(i);
                end else begin
                    out_q[i] <= '0;
                    idx_q[i] <= '0;
                end
            end
            inserted <= therm;
            tail     <= tail + IDX_W'(n);
            occ      <= occ_next;
            if (flushInst) begin
                count  <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                count  <= count + (PW+1)'(n_acc) - (PW+1)'(n);
                rd_ptr <= rd_ptr + PW'(n);
                wr_ptr <= wr_ptr + PW'(n_acc);
            end
        end
    end

`ifdef DISPATCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCycles     <= '0;
            dispatchedTotal <= '0;
        end else begin
            if (count != '0 && n == 3'd0 && !flushInst)
                stallCycles <= stallCycles + 32'd1;
            dispatchedTotal <= dispatchedTotal + 32'(n);
        end
    end
`endif

    assign archReg0 = out_q[0].arch;
    assign archReg1 = out_q[1].arch;
    assign archReg2 = out_q[2].arch;
    assign archReg3 = out_q[3].arch;
    assign physReg0 = out_q[0].phys;
    assign physReg1 = out_q[1].phys;
    assign physReg2 = out_q[2].phys;
    assign physReg3 = out_q[3].phys;
    assign opcode0  = out_q[0].op;
    assign opcode1  = out_q[1].op;
    assign opcode2  = out_q[2].op;
    assign opcode3  = out_q[3].op;
    assign robIndex0 = idx_q[0];
    assign robIndex1 = idx_q[1];
    assign robIndex2 = idx_q[2];
    assign robIndex3 = idx_q[3];
    assign robOccupancy = occ;

endmodule

// File: tb/tb_rob_dispatch.sv
// Scoreboard bench for rob_dispatch: a queue-based reference model predicts each cycle's ROB insertion.
module tb_rob_dispatch;

    localparam int QDEPTH = 8;
    localparam int ROB_SIZE = 128;
    localparam int IDX_W = 7;

    logic clk = 0;
    logic reset;
    logic [3:0] in_valid;
    logic [4:0] ar [4];
    logic [7:0] pr [4];
    logic [10:0] op [4];
    logic in_ready;
    logic [2:0] numCommited;
    logic full, flushInst;
    logic [3:0] inserted;
    logic [4:0] archReg0, archReg1, archReg2, archReg3;
    logic [7:0] physReg0, physReg1, physReg2, physReg3;
    logic [10:0] opcode0, opcode1, opcode2, opcode3;
    logic [IDX_W-1:0] robIndex0, robIndex1, robIndex2, robIndex3;
    logic [IDX_W:0] robOccupancy;
`ifdef DISPATCH_STATS_EN
    logic [31:0] stallCycles, dispatchedTotal;
`endif

    always #5 clk = ~clk;

    rob_dispatch #(.QDEPTH(QDEPTH), .ROB_SIZE(ROB_SIZE), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .in_archReg0(ar[0]), .in_archReg1(ar[1]), .in_archReg2(ar[2]), .in_archReg3(ar[3]),
        .in_physReg0(pr[0]), .in_physReg1(pr[1]), .in_physReg2(pr[2]), .in_physReg3(pr[3]),
        .in_opcode0(op[0]), .in_opcode1(op[1]), .in_opcode2(op[2]), .in_opcode3(op[3]),
        .in_ready(in_ready), .numCommited(numCommited), .full(full), .flushInst(flushInst),
        .inserted(inserted),
        .archReg0(archReg0), .archReg1(archReg1), .archReg2(archReg2), .archReg3(archReg3),
        .physReg0(physReg0), .physReg1(physReg1), .physReg2(physReg2), .physReg3(physReg3),
        .opcode0(opcode0), .opcode1(opcode1), .opcode2(opcode2), .opcode3(opcode3),
        .robIndex0(robIndex0), .robIndex1(robIndex1), .robIndex2(robIndex2), .robIndex3(robIndex3),
        .robOccupancy(robOccupancy)
`ifdef DISPATCH_STATS_EN
        , .stallCycles(stallCycles), .dispatchedTotal(dispatchedTotal)
`endif
    );

    typedef struct {
        logic [4:0]  a;
        logic [7:0]  p;
        logic [10:0] o;
    } ent_t;

    typedef struct {
        int stamp;
        logic [3:0] ins;
        logic [3:0][4:0] a;
        logic [3:0][7:0] p;
        logic [3:0][10:0] o;
        logic [3:0][IDX_W-1:0] idx;
        logic [IDX_W:0] occ;
    } exp_t;

    ent_t mq[$];
    exp_t eq[$];
    int m_occ = 0;
    int m_tail = 0;
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    // One stimulus cycle: drive inputs at the falling edge and predict the next rising edge.
    task automatic step(input logic [3:0] v, input int numc, input bit f, input bit fl, input bit rst);
        exp_t e;
        int n, room;
        bit rdy;
        ent_t x;
        @(negedge clk);
        rdy = (QDEPTH - mq.size()) >= 4;
        if (cyc > 0) chk("in_ready", in_ready, rdy);
        reset = rst;
        in_valid = v;
        numCommited = 3'(numc);
        full = f;
        flushInst = fl;
        for (int i = 0; i < 4; i++) begin
            ar[i] = 5'($urandom);
            pr[i] = 8'($urandom);
            op[i] = 11'($urandom);
        end
        e.stamp = cyc + 1;
        e.ins = '0; e.a = '0; e.p = '0; e.o = '0; e.idx = '0; e.occ = '0;
        if (rst) begin
            mq.delete();
            m_occ = 0;
            m_tail = 0;
        end else begin
            n = 0;
            if (!f && !fl) begin
                room = ROB_SIZE - m_occ;
                n = mq.size();
                if (n > 4) n = 4;
                if (n > room) n = room;
            end
            for (int i = 0; i < n; i++) begin
                x = mq.pop_front();
                e.ins[i] = 1'b1;
                e.a[i] = x.a;
                e.p[i] = x.p;
                e.o[i] = x.o;
                e.idx[i] = IDX_W'((m_tail + i) % ROB_SIZE);
            end
            m_tail = (m_tail + n) % ROB_SIZE;
            m_occ = m_occ + n - numc;
            if (m_occ < 0) m_occ = 0;
            if (fl) mq.delete();
            else if (rdy)
                for (int i = 0; i < 4; i++)
                    if (v[i]) begin
                        x.a = ar[i]; x.p = pr[i]; x.o = op[i];
                        mq.push_back(x);
                    end
            e.occ = (IDX_W+1)'(m_occ);
        end
        eq.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (eq.size() > 0 && eq[0].stamp <= cyc) begin
            e = eq.pop_front();
            chk("inserted", inserted, e.ins);
            chk("archReg0", archReg0, e.a[0]);
            chk("archReg1", archReg1, e.a[1]);
            chk("archReg2", archReg2, e.a[2]);
            chk("archReg3", archReg3, e.a[3]);
            chk("physReg0", physReg0, e.p[0]);
            chk("physReg1", physReg1, e.p[1]);
            chk("physReg2", physReg2, e.p[2]);
            chk("physReg3", physReg3, e.p[3]);
            chk("opcode0", opcode0, e.o[0]);
            chk("opcode1", opcode1, e.o[1]);
            chk("opcode2", opcode2, e.o[2]);
            chk("opcode3", opcode3, e.o[3]);
            chk("robIndex0", robIndex0, e.idx[0]);
            chk("robIndex1", robIndex1, e.idx[1]);
            chk("robIndex2", robIndex2, e.idx[2]);
            chk("robIndex3", robIndex3, e.idx[3]);
            chk("robOccupancy", robOccupancy, e.occ);
        end
    end

    initial begin
        int r;
        reset = 1; in_valid = 0; numCommited = 0; full = 0; flushInst = 0;
        for (int i = 0; i < 4; i++) begin ar[i] = 0; pr[i] = 0; op[i] = 0; end
        repeat (3) step(4'b0000, 0, 0, 0, 1);
        // single full group, then a sparse mask
        step(4'b1111, 0, 0, 0, 0);
        repeat (2) step(4'b0000, 0, 0, 0, 0);
        step(4'b0101, 0, 0, 0, 0);
        repeat (2) step(4'b0000, 0, 0, 0, 0);
        // run the ROB out of credit with a backed-up queue
        repeat (40) step(4'b1111, 0, 0, 0, 0);
        repeat (3) step(4'b0000, 4, 0, 0, 0);
        repeat (3) step(4'b0000, 0, 0, 0, 0);
        repeat (10) step(4'b0000, 4, 0, 0, 0);
        // stall on full with 8 queued, then release
        repeat (6) step(4'b1111, 4, 1, 0, 0);
        repeat (4) step(4'b0000, 0, 0, 0, 0);
        // flush with a loaded queue and simultaneous commits/inputs
        repeat (2) step(4'b1111, 0, 1, 0, 0);
        step(4'b1111, 2, 0, 1, 0);
        repeat (3) step(4'b0000, 0, 0, 0, 0);
        // over-commit saturates occupancy at zero
        repeat (40) step(4'b0000, 4, 0, 0, 0);
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 999);
            step(4'($urandom), $urandom_range(0, 4), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 39) == 0), (r == 0));
        end
        repeat (2) step(4'b0000, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", eq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
